chaos_engine_arb: RTL

Round-robin arbiter and sequencer that shares one `chaotic_seq` engine between `NUM_REQ` requesters (e.g. the theta and z generators of the propagation-matrix PE). It accepts an initial value x0 from one requester, issues it to the engine, waits for the iterated result, and returns it to the originating requester. Exactly one job is outstanding at any time.

---
 rtl/chaos_engine_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/chaos_engine_arb.sv
// chaos_engine_arb: round-robin arbiter/sequencer sharing one chaotic_seq
// engine between NUM_REQ requesters. One job in flight at a time:
// accept x0 -> issue to engine -> wait for result -> return to the owner.
//
// Handshakes: a transfer happens on a rising clk edge where both vld and rdy
// are high; the sender holds vld and data stable until that edge.
module chaos_engine_arb #(
    parameter int NUM_REQ      = 2,
    parameter int CHAOS_OVLD_W = 32,
    parameter int CNT_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ*CHAOS_OVLD_W-1:0] req_x0,
    input  logic [NUM_REQ-1:0]              req_x0_vld,
    output logic [NUM_REQ-1:0]              req_x0_rdy,
    output logic [CHAOS_OVLD_W-1:0]         req_xout,
    output logic [NUM_REQ-1:0]              req_xout_vld,
    input  logic [NUM_REQ-1:0]              req_xout_rdy,
    output logic [CHAOS_OVLD_W-1:0]         eng_x0,
    output logic                            eng_x0_vld,
    input  logic                            eng_x0_rdy,
    input  logic [CHAOS_OVLD_W-1:0]         eng_xout,
    input  logic                            eng_xout_vld,
    output logic                            eng_xout_rdy,
    output logic                            busy,
    output logic [2:0]                      owner_id,
    output logic [CNT_W-1:0]                job_cnt,
    output logic [1:0]                      fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t                  state;
    logic [2:0]              ptr;
    logic [CHAOS_OVLD_W-1:0] x0_q;
    logic [CHAOS_OVLD_W-1:0] res_q;

    logic                    found_hi;
    logic                    found_any;
    logic [2:0]              idx_hi;
    logic [2:0]              idx_lo;
    logic [2:0]              grant_idx;
    logic [CHAOS_OVLD_W-1:0] x0_sel;
    logic                    ret_ack;
    logic [2:0]              next_ptr;

    assign eng_x0    = x0_q;
    assign req_xout  = res_q;
    assign fsm_state = state;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = 3'd0;
        idx_lo    = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_x0_vld[i]) begin
                found_any = 1'b1;
                idx_lo    = 3'(i);
                if (3'(i) >= ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = 3'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
    end

    // Ready goes only to the granted requester, and only while idle.
    always_comb begin
        req_x0_rdy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x0_rdy[i] = (state == ST_IDLE) && found_any && (grant_idx == 3'(i));
        end
    end

    // Select the granted requester's x0 lane and the owner's result-ready bit.
    always_comb begin
        x0_sel  = '0;
        ret_ack = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) x0_sel = req_x0[i*CHAOS_OVLD_W +: CHAOS_OVLD_W];
            if (owner_id == 3'(i))  ret_ack = req_xout_rdy[i];
        end
        next_ptr = (owner_id == 3'(NUM_REQ - 1)) ? 3'd0 : owner_id + 3'd1;
    end

    // Job sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= 3'd0;
            owner_id     <= 3'd0;
            x0_q         <= '0;
            res_q        <= '0;
            job_cnt      <= '0;
            busy         <= 1'b0;
            eng_x0_vld   <= 1'b0;
            eng_xout_rdy <= 1'b0;
            req_xout_vld <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found_any) begin
                        x0_q       <= x0_sel;
                        owner_id   <= grant_idx;
                        busy       <= 1'b1;
                        eng_x0_vld <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (eng_x0_rdy) begin
                        eng_x0_vld   <= 1'b0;
                        eng_xout_rdy <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_xout_vld) begin
                        res_q        <= eng_xout;
                        eng_xout_rdy <= 1'b0;
                        req_xout_vld <= NUM_REQ'(1) << owner_id;
                        state        <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (ret_ack) begin
                        req_xout_vld <= '0;
                        job_cnt      <= job_cnt + 1'b1;
                        ptr          <= next_ptr;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
